// File: rtl/ext_cpu_lockstep_voter.sv
`default_nettype none
// ============================================================================
//  Module      : ext_cpu_lockstep_voter
//  Description : OBI data-port voter/arbiter between NHARTS hart data ports
//                and the system bus. Harts run independently (pass-through),
//                or harts 0..1 (DMR) / 0..2 (TMR) run in lockstep with one
//                voted request on bus lane 0, the response broadcast to the
//                group, and divergence flagged and counted.
//                Optional feature macro: LOCKSTEP_HALT_ON_MISMATCH_EN
//                (halt the group through debug_req_o on divergence).
//  Packing     : req  lane = {req, we, be[3:0], addr[31:0], wdata[31:0]} (70b)
//                resp lane = {gnt, rvalid, rdata[31:0]}                  (34b)
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_cpu_lockstep_voter #(
  parameter int NHARTS    = 3,
  parameter int CNT_W     = 8,
  parameter int MAX_OUTST = 2,
  localparam int C_REQ_W  = 70,
  localparam int C_RSP_W  = 34
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                mode_req_i,
  input  logic                      mode_valid_i,
  output logic                      mode_ready_o,
  output logic [1:0]                mode_o,
  input  logic [NHARTS-1:0]         sleep_i,
  input  logic [NHARTS*C_REQ_W-1:0] core_data_req_i,
  output logic [NHARTS*C_RSP_W-1:0] core_data_resp_o,
  output logic [NHARTS*C_REQ_W-1:0] bus_data_req_o,
  input  logic [NHARTS*C_RSP_W-1:0] bus_data_resp_i,
  output logic                      mismatch_o,
  output logic [NHARTS-1:0]         mismatch_hart_o,
  output logic [CNT_W-1:0]          mismatch_cnt_o,
  output logic [NHARTS-1:0]         debug_req_o
);

  localparam int         C_OW       = $clog2(MAX_OUTST + 1);
  // Third lockstep hart index; folds to 0 on builds too small for TMR.
  localparam int         C_H2       = (NHARTS >= 3) ? 2 : 0;
  localparam logic [1:0] C_MODE_IND = 2'd0;
  localparam logic [1:0] C_MODE_DMR = 2'd1;
  localparam logic [1:0] C_MODE_TMR = 2'd2;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_SWITCH = 2'd2} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [1:0]          r_target;
  logic                r_mode_ready;
  logic [C_OW-1:0]     r_outst [NHARTS];
  logic                r_mismatch;
  logic [NHARTS-1:0]   r_mis_hart;
  logic [NHARTS-1:0]   r_debug;
  logic [CNT_W-1:0]    r_cnt;

  logic [NHARTS-1:0]   w_grp;
  logic [NHARTS-1:0]   w_hreq;
  logic [NHARTS-1:0]   w_full;
  logic [NHARTS-1:0]   w_live;
  logic [NHARTS-1:0]   w_issue;
  logic [NHARTS-1:0]   w_ret;
  logic [NHARTS-1:0]   w_minority;
  logic [NHARTS-1:0]   w_dbg_set;
  logic [C_REQ_W-1:0]  w_h0, w_h1, w_h2, w_vote;
  logic                w_eq01, w_eq02, w_eq12;
  logic                w_any_req, w_mis, w_halt;
  logic                w_idle, w_drain_done, w_legal;

  // Harts belonging to the lockstep group of a given mode.
  function automatic logic [NHARTS-1:0] grp_mask(input logic [1:0] m);
    logic [NHARTS-1:0] v;
    v = '0;
    for (int k = 0; k < NHARTS; k++)
      v[k] = ((m == C_MODE_DMR) && (k < 2)) || ((m == C_MODE_TMR) && (k < 3));
    return v;
  endfunction

  assign w_grp  = grp_mask(r_mode);
  assign w_h0   = core_data_req_i[0 +: C_REQ_W];
  assign w_h1   = core_data_req_i[C_REQ_W +: C_REQ_W];
  assign w_h2   = core_data_req_i[C_H2*C_REQ_W +: C_REQ_W];
  assign w_eq01 = (w_h0 == w_h1);
  assign w_eq02 = (w_h0 == w_h2);
  assign w_eq12 = (w_h1 == w_h2);
  // TMR drives the bitwise majority; DMR trusts hart 0.
  assign w_vote = (r_mode == C_MODE_TMR) ? ((w_h0 & w_h1) | (w_h0 & w_h2) | (w_h1 & w_h2)) : w_h0;
  assign w_any_req = |(w_hreq & w_grp);
  assign w_legal = (mode_req_i == C_MODE_IND) || (mode_req_i == C_MODE_DMR) ||
                   ((mode_req_i == C_MODE_TMR) && (NHARTS >= 3));
  assign w_drain_done = w_idle && (&(sleep_i | ~(grp_mask(r_mode) | grp_mask(r_target))));

`ifdef LOCKSTEP_HALT_ON_MISMATCH_EN
  // A diverging DMR pair cannot be voted, so its request is withheld.
  assign w_halt    = w_mis && (r_mode == C_MODE_DMR);
  assign w_dbg_set = w_minority;
`else
  assign w_halt    = 1'b0;
  assign w_dbg_set = '0;
`endif

  // Per-lane request bit and outstanding-counter status flags.
  always_comb begin
    w_hreq = '0;
    w_full = '0;
    w_live = '0;
    w_idle = 1'b1;
    for (int i = 0; i < NHARTS; i++) begin
      w_hreq[i] = core_data_req_i[i*C_REQ_W + C_REQ_W - 1];
      w_full[i] = (r_outst[i] == C_OW'(MAX_OUTST));
      w_live[i] = (r_outst[i] != '0);
      if (r_outst[i] != '0) w_idle = 1'b0;
    end
  end

  // Divergence detection and identification of the offending hart(s).
  always_comb begin
    w_mis      = 1'b0;
    w_minority = '0;
    if (w_any_req && (r_mode == C_MODE_DMR) && !w_eq01) begin
      w_mis         = 1'b1;
      w_minority[0] = 1'b1;
      w_minority[1] = 1'b1;
    end else if (w_any_req && (r_mode == C_MODE_TMR) && !(w_eq01 && w_eq02)) begin
      w_mis = 1'b1;
      if (w_eq01)      w_minority[C_H2] = 1'b1;
      else if (w_eq02) w_minority[1]    = 1'b1;
      else if (w_eq12) w_minority[0]    = 1'b1;
      else begin
        w_minority[0]    = 1'b1;
        w_minority[1]    = 1'b1;
        w_minority[C_H2] = 1'b1;
      end
    end
  end

  // Lane routing: pass-through outside the group, vote/broadcast inside it.
  always_comb begin
    bus_data_req_o   = '0;
    core_data_resp_o = '0;
    w_issue          = '0;
    w_ret            = '0;
    for (int i = 0; i < NHARTS; i++) begin
      if (!w_grp[i]) begin
        bus_data_req_o[i*C_REQ_W +: C_REQ_W]           = core_data_req_i[i*C_REQ_W +: C_REQ_W];
        bus_data_req_o[i*C_REQ_W + C_REQ_W - 1]        = w_hreq[i] & ~w_full[i];
        core_data_resp_o[i*C_RSP_W +: C_RSP_W]         = bus_data_resp_i[i*C_RSP_W +: C_RSP_W];
        core_data_resp_o[i*C_RSP_W + C_RSP_W - 1]      = bus_data_resp_i[i*C_RSP_W + C_RSP_W - 1] & ~w_full[i];
        core_data_resp_o[i*C_RSP_W + C_RSP_W - 2]      = bus_data_resp_i[i*C_RSP_W + C_RSP_W - 2] & w_live[i];
      end else begin
        if (i == 0) begin
          bus_data_req_o[0 +: C_REQ_W]                 = w_vote;
          bus_data_req_o[C_REQ_W - 1]                  = w_vote[C_REQ_W - 1] & ~w_full[0] & ~w_halt;
        end
        core_data_resp_o[i*C_RSP_W +: C_RSP_W]         = bus_data_resp_i[0 +: C_RSP_W];
        core_data_resp_o[i*C_RSP_W + C_RSP_W - 1]      = bus_data_resp_i[C_RSP_W - 1] & ~w_full[0] & ~w_halt;
        core_data_resp_o[i*C_RSP_W + C_RSP_W - 2]      = bus_data_resp_i[C_RSP_W - 2] & w_live[0];
      end
    end
    for (int i = 0; i < NHARTS; i++) begin
      w_issue[i] = bus_data_req_o[i*C_REQ_W + C_REQ_W - 1] & bus_data_resp_i[i*C_RSP_W + C_RSP_W - 1];
      w_ret[i]   = bus_data_resp_i[i*C_RSP_W + C_RSP_W - 2] & w_live[i];
    end
  end

  // Outstanding transactions per bus lane; rvalid with nothing pending is dropped.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NHARTS; i++) begin
      if (rst_i)                         r_outst[i] <= '0;
      else if (w_issue[i] && !w_ret[i])  r_outst[i] <= r_outst[i] + 1'b1;
      else if (!w_issue[i] && w_ret[i])  r_outst[i] <= r_outst[i] - 1'b1;
    end
  end

  // Mode-change FSM: drain traffic and wait for sleeping harts before switching.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_RUN;
      r_mode       <= C_MODE_IND;
      r_target     <= C_MODE_IND;
      r_mode_ready <= 1'b0;
    end else begin
      r_mode_ready <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (mode_valid_i && w_legal) begin
            r_target <= mode_req_i;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) r_state <= S_SWITCH;
        end
        S_SWITCH: begin
          r_mode       <= r_target;
          r_mode_ready <= 1'b1;
          r_state      <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Divergence pulse, saturating count, sticky hart flags and halt requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
      r_mis_hart <= '0;
      r_debug    <= '0;
    end else begin
      r_mismatch <= w_mis;
      if (w_mis && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_SWITCH) begin
        r_mis_hart <= '0;
        r_debug    <= '0;
      end else if (w_mis) begin
        r_mis_hart <= r_mis_hart | w_minority;
        r_debug    <= r_debug | w_dbg_set;
      end
    end
  end

  assign mode_o          = r_mode;
  assign mode_ready_o    = r_mode_ready;
  assign mismatch_o      = r_mismatch;
  assign mismatch_hart_o = r_mis_hart;
  assign mismatch_cnt_o  = r_cnt;
  assign debug_req_o     = r_debug;

endmodule
`default_nettype wire

// File: tb/tb_ext_cpu_lockstep_voter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_cpu_lockstep_voter
//  Description : Directed, table-driven bench for ext_cpu_lockstep_voter.
//                A second instance with CNT_W=2 shares the stimulus to show
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_cpu_lockstep_voter;

  localparam int NH = 3;
  localparam int RQ = 70;
  localparam int RS = 34;
`ifdef LOCKSTEP_HALT_ON_MISMATCH_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode_req;
  logic              mode_valid;
  logic [NH-1:0]     sleep;
  logic [NH*RQ-1:0]  core_req;
  logic [NH*RS-1:0]  bus_rsp;
  logic              mode_ready;
  logic [1:0]        mode;
  logic [NH*RS-1:0]  core_rsp;
  logic [NH*RQ-1:0]  bus_req;
  logic              mis;
  logic [NH-1:0]     mis_hart;
  logic [7:0]        mis_cnt;
  logic [NH-1:0]     dbg;
  logic              s_ready;
  logic [1:0]        s_mode;
  logic [NH*RS-1:0]  s_core_rsp;
  logic [NH*RQ-1:0]  s_bus_req;
  logic              s_mis;
  logic [NH-1:0]     s_hart;
  logic [1:0]        s_cnt;
  logic [NH-1:0]     s_dbg;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_cpu_lockstep_voter #(.NHARTS(NH), .CNT_W(8), .MAX_OUTST(2)) dut (
    .clk_i(clk), .rst_i(rst), .mode_req_i(mode_req), .mode_valid_i(mode_valid),
    .mode_ready_o(mode_ready), .mode_o(mode), .sleep_i(sleep),
    .core_data_req_i(core_req), .core_data_resp_o(core_rsp),
    .bus_data_req_o(bus_req), .bus_data_resp_i(bus_rsp),
    .mismatch_o(mis), .mismatch_hart_o(mis_hart), .mismatch_cnt_o(mis_cnt),
    .debug_req_o(dbg));

  ext_cpu_lockstep_voter #(.NHARTS(NH), .CNT_W(2), .MAX_OUTST(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .mode_req_i(mode_req), .mode_valid_i(mode_valid),
    .mode_ready_o(s_ready), .mode_o(s_mode), .sleep_i(sleep),
    .core_data_req_i(core_req), .core_data_resp_o(s_core_rsp),
    .bus_data_req_o(s_bus_req), .bus_data_resp_i(bus_rsp),
    .mismatch_o(s_mis), .mismatch_hart_o(s_hart), .mismatch_cnt_o(s_cnt),
    .debug_req_o(s_dbg));

  typedef struct {
    logic [31:0] a0, a1, a2, w0, w1, w2;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_mis;
    logic [2:0]  exp_hart;
    logic [7:0]  exp_cnt;
    logic [1:0]  exp_sat;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hart(input int h, input logic rq, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd);
    core_req[h*RQ +: RQ] = {rq, we, 4'hF, addr, wd};
  endtask

  task automatic set_bus(input int l, input logic gnt, input logic rv, input logic [31:0] rd);
    bus_rsp[l*RS +: RS] = {gnt, rv, rd};
  endtask

  task automatic clear_all();
    core_req = '0;
    bus_rsp  = '0;
  endtask

  function automatic logic        b_req(input int l);   return bus_req[l*RQ + 69];      endfunction
  function automatic logic [31:0] b_addr(input int l);  return bus_req[l*RQ + 32 +: 32]; endfunction
  function automatic logic [31:0] b_wdata(input int l); return bus_req[l*RQ +: 32];      endfunction
  function automatic logic        c_gnt(input int h);   return core_rsp[h*RS + 33];     endfunction
  function automatic logic        c_rv(input int h);    return core_rsp[h*RS + 32];     endfunction
  function automatic logic [31:0] c_rd(input int h);    return core_rsp[h*RS +: 32];    endfunction

  task automatic do_switch(input logic [1:0] m);
    bit ok;
    mode_req   = m;
    mode_valid = 1'b1;
    tick();
    mode_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("switch_ready_seen", 32'(ok), 32'd1);
    chk("switch_mode", 32'(mode), 32'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tv[0] = '{32'h100, 32'h100, 32'h104, 32'hA, 32'hA, 32'hA, 32'h100, 32'hA, 1'b1, 3'b100, 8'd1, 2'd1};
    tv[1] = '{32'h200, 32'h200, 32'h200, 32'h5, 32'h5, 32'h5, 32'h200, 32'h5, 1'b0, 3'b100, 8'd1, 2'd1};
    tv[2] = '{32'h308, 32'h300, 32'h300, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 1'b1, 3'b101, 8'd2, 2'd2};
    tv[3] = '{32'h40, 32'h40, 32'h40, 32'hFF00, 32'h00FF, 32'hFF00, 32'h40, 32'hFF00, 1'b1, 3'b111, 8'd3, 2'd3};
    tv[4] = '{32'h1, 32'h2, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b111, 8'd4, 2'd3};
    tv[5] = '{32'h3, 32'h5, 32'h6, 32'h11111111, 32'h22222222, 32'h44444444, 32'h7, 32'h0, 1'b1, 3'b111, 8'd5, 2'd3};

    rst = 1'b1; mode_req = 2'd0; mode_valid = 1'b0; sleep = '0;
    clear_all();
    repeat (3) tick();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_ready", 32'(mode_ready), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_hart", 32'(mis_hart), 32'd0);
    chk("rst_cnt", 32'(mis_cnt), 32'd0);
    chk("rst_dbg", 32'(dbg), 32'd0);
    rst = 1'b0;
    tick();

    // Independent pass-through on lane 1.
    set_hart(1, 1'b1, 1'b1, 32'h2000_0010, 32'hDEADBEEF);
    set_bus(1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("ind_bus_req1", 32'(b_req(1)), 32'd1);
    chk("ind_bus_addr1", b_addr(1), 32'h2000_0010);
    chk("ind_bus_wdata1", b_wdata(1), 32'hDEADBEEF);
    chk("ind_bus_req0", 32'(b_req(0)), 32'd0);
    chk("ind_gnt", 32'({c_gnt(2), c_gnt(1), c_gnt(0)}), 32'b010);
    tick();
    clear_all();
    set_bus(1, 1'b0, 1'b1, 32'h12345678);
    #1;
    chk("ind_rvalid", 32'({c_rv(2), c_rv(1), c_rv(0)}), 32'b010);
    chk("ind_rdata1", c_rd(1), 32'h12345678);
    chk("ind_mis", 32'(mis), 32'd0);
    tick();
    clear_all();

    // Switch to TMR while hart 0 has one transaction outstanding.
    set_hart(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    set_bus(0, 1'b1, 1'b0, 32'h0);
    tick();
    clear_all();
    sleep = 3'b111;
    mode_req = 2'd2;
    mode_valid = 1'b1;
    tick();
    mode_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mode_ready) seen = 1'b1;
    end
    chk("drain_hold_ready", 32'(seen), 32'd0);
    chk("drain_hold_mode", 32'(mode), 32'd0);
    set_bus(0, 1'b0, 1'b1, 32'hAA);
    tick();
    clear_all();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmr_ready_seen", 32'(seen), 32'd1);
    chk("tmr_mode", 32'(mode), 32'd2);
    tick();
    chk("tmr_ready_pulse", 32'(mode_ready), 32'd0);

    // TMR vote table.
    for (int i = 0; i < 6; i++) begin
      set_hart(0, 1'b1, 1'b1, tv[i].a0, tv[i].w0);
      set_hart(1, 1'b1, 1'b1, tv[i].a1, tv[i].w1);
      set_hart(2, 1'b1, 1'b1, tv[i].a2, tv[i].w2);
      set_bus(0, 1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("v%0d_addr", i), b_addr(0), tv[i].exp_addr);
      chk($sformatf("v%0d_wdata", i), b_wdata(0), tv[i].exp_wdata);
      chk($sformatf("v%0d_req", i), 32'({b_req(2), b_req(1), b_req(0)}), 32'b001);
      chk($sformatf("v%0d_gnt", i), 32'({c_gnt(2), c_gnt(1), c_gnt(0)}), 32'b111);
      tick();
      clear_all();
      set_bus(0, 1'b0, 1'b1, 32'hC0DE0000 + 32'(i));
      #1;
      chk($sformatf("v%0d_mis", i), 32'(mis), 32'(tv[i].exp_mis));
      chk($sformatf("v%0d_hart", i), 32'(mis_hart), 32'(tv[i].exp_hart));
      chk($sformatf("v%0d_cnt", i), 32'(mis_cnt), 32'(tv[i].exp_cnt));
      chk($sformatf("v%0d_satcnt", i), 32'(s_cnt), 32'(tv[i].exp_sat));
      chk($sformatf("v%0d_dbg", i), 32'(dbg), HALT ? 32'(tv[i].exp_hart) : 32'd0);
      chk($sformatf("v%0d_rv", i), 32'({c_rv(2), c_rv(1), c_rv(0)}), 32'b111);
      chk($sformatf("v%0d_rd0", i), c_rd(0), 32'hC0DE0000 + 32'(i));
      chk($sformatf("v%0d_rd2", i), c_rd(2), 32'hC0DE0000 + 32'(i));
      tick();
      clear_all();
      chk($sformatf("v%0d_mis_end", i), 32'(mis), 32'd0);
    end

    // Outstanding limit on the voted lane.
    for (int h = 0; h < 3; h++) set_hart(h, 1'b1, 1'b0, 32'h500, 32'h0);
    set_bus(0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    chk("lim_req_full", 32'(b_req(0)), 32'd0);
    chk("lim_gnt_full", 32'(c_gnt(0)), 32'd0);
    tick();
    chk("lim_req_still", 32'(b_req(0)), 32'd0);
    set_bus(0, 1'b1, 1'b1, 32'h99);
    #1;
    chk("lim_req_rv_cycle", 32'(b_req(0)), 32'd0);
    tick();
    set_bus(0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("lim_req_release", 32'(b_req(0)), 32'd1);
    chk("lim_gnt_release", 32'({c_gnt(2), c_gnt(1), c_gnt(0)}), 32'b111);
    tick();
    clear_all();
    set_bus(0, 1'b0, 1'b1, 32'h0);
    tick();
    tick();
    clear_all();
    chk("lim_cnt_kept", 32'(mis_cnt), 32'd5);

    // Reserved mode is ignored.
    mode_req = 2'd3;
    mode_valid = 1'b1;
    tick();
    mode_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mode_ready) seen = 1'b1;
    end
    chk("rsv_ready", 32'(seen), 32'd0);
    chk("rsv_mode", 32'(mode), 32'd2);

    // Switch to DMR: sticky flags cleared, count kept.
    do_switch(2'd1);
    chk("dmr_hart_clr", 32'(mis_hart), 32'd0);
    chk("dmr_cnt_kept", 32'(mis_cnt), 32'd5);
    chk("dmr_dbg_clr", 32'(dbg), 32'd0);

    // DMR divergence; hart 2 stays pass-through.
    set_hart(0, 1'b1, 1'b1, 32'h600, 32'h1);
    set_hart(1, 1'b1, 1'b1, 32'h600, 32'h2);
    set_hart(2, 1'b1, 1'b1, 32'h777, 32'h77);
    set_bus(0, 1'b1, 1'b0, 32'h0);
    set_bus(2, 1'b1, 1'b0, 32'h0);
    #1;
    chk("dmr_bus_req0", 32'(b_req(0)), HALT ? 32'd0 : 32'd1);
    chk("dmr_gnt01", 32'({c_gnt(1), c_gnt(0)}), HALT ? 32'd0 : 32'd3);
    chk("dmr_wdata0", b_wdata(0), 32'h1);
    chk("dmr_bus_req1", 32'(b_req(1)), 32'd0);
    chk("dmr_lane2_addr", b_addr(2), 32'h777);
    chk("dmr_lane2_gnt", 32'(c_gnt(2)), 32'd1);
    tick();
    clear_all();
    chk("dmr_mis", 32'(mis), 32'd1);
    chk("dmr_hart", 32'(mis_hart), 32'b011);
    chk("dmr_cnt", 32'(mis_cnt), 32'd6);
    chk("dmr_dbg", 32'(dbg), HALT ? 32'd3 : 32'd0);
    tick();
    chk("dmr_dbg_held", 32'(dbg), HALT ? 32'd3 : 32'd0);
    chk("dmr_mis_end", 32'(mis), 32'd0);
    set_bus(0, 1'b0, 1'b1, 32'h0);
    set_bus(2, 1'b0, 1'b1, 32'h0);
    tick();
    clear_all();

    // Back to independent mode releases the halt.
    do_switch(2'd0);
    chk("ind_dbg_clr", 32'(dbg), 32'd0);
    chk("ind_hart_clr", 32'(mis_hart), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_cpu_lockstep_voter.md
Name: ext_cpu_lockstep_voter

Overview:
- Parametrised OBI data-port arbiter/voter between NHARTS cv32e20 data ports and the system bus.
- Runs harts independently (pass-through), or groups harts 0..1 (DMR) or 0..2 (TMR) in lockstep.
- In lockstep: one voted request per group goes to the bus; the response is broadcast to the group; divergence is flagged and counted.
- Sits between the external CPU system's core_data_req/resp arrays and the bus crossbar.

Parameters:
- NHARTS, 3, number of hart data ports; must be >= 3 for TMR.
- CNT_W, 8, width of the saturating mismatch counter.
- MAX_OUTST, 2, maximum outstanding (granted, not yet rvalid) transactions per lane.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- mode_req_i  in  2  requested mode: 0 independent, 1 DMR, 2 TMR; 3 is reserved.
- mode_valid_i  in  1  mode-change request strobe.
- mode_ready_o  out  1  mode change accepted this cycle.
- mode_o  out  2  current mode.
- sleep_i  in  NHARTS  per-hart core_sleep.
- core_data_req_i  in  NHARTS x obi_req_t  hart requests.
- core_data_resp_o  out  NHARTS x obi_resp_t  hart responses.
- bus_data_req_o  out  NHARTS x obi_req_t  bus requests.
- bus_data_resp_i  in  NHARTS x obi_resp_t  bus responses.
- mismatch_o  out  1  one-cycle divergence pulse.
- mismatch_hart_o  out  NHARTS  diverging hart(s), sticky until the next mode change.
- mismatch_cnt_o  out  CNT_W  saturating divergence count.
- debug_req_o  out  NHARTS  halt request to harts.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: mode_o=0, FSM=RUN, all counters=0, mismatch_o=0, mismatch_hart_o=0, mismatch_cnt_o=0, debug_req_o=0, mode_ready_o=0.
- Independent mode: lane i passes straight through (req and resp) with zero latency. Per-lane outstanding counter: +1 on req&gnt, -1 on rvalid; +1 and -1 in the same cycle leaves it unchanged.
- Group: G = {0,1} in DMR, {0,1,2} in TMR. Lanes not in G stay pass-through.
- Lockstep compare, done only in cycles where any hart in G asserts req:
  - Compare req, we, be, addr, wdata across G.
  - TMR: bus lane 0 carries the bitwise majority of the three harts' fields.
  - DMR: bus lane 0 carries hart 0's fields.
  - Bus lanes 1..|G|-1 are driven all-zero.
- Lockstep response: bus lane 0 gnt/rvalid/rdata are broadcast to every hart in G, same cycle.
- Mismatch detection:
  - Any field differs within G → mismatch_o pulses on the next cycle.
  - mismatch_cnt_o increments and saturates at 2^CNT_W-1.
  - TMR: the minority hart's bit is OR'd into mismatch_hart_o; a three-way disagreement sets all three bits.
  - DMR: bits 0 and 1 are both set.
- FSM states RUN, DRAIN, SWITCH:
  - RUN: mode_valid_i with a legal mode → DRAIN. A reserved mode, or TMR with NHARTS<3, is ignored; mode_ready_o stays 0.
  - DRAIN: hold the target mode and keep forwarding traffic. Go to SWITCH when all outstanding counters = 0 and all harts in the union of the old and new groups have sleep_i=1.
  - SWITCH: update mode_o, clear mismatch_hart_o, pulse mode_ready_o for one cycle, return to RUN. mismatch_cnt_o is not cleared.
- mode_valid_i while in DRAIN or SWITCH: ignored.
- Requesting the current mode still traverses DRAIN → SWITCH.
- Outstanding counter at MAX_OUTST: gnt to that hart is masked to 0 and bus req is suppressed until the counter decrements.
- Reset mid-transaction: all state is discarded; no rvalid is forwarded after reset.

Optional Feature:
- Macro: LOCKSTEP_HALT_ON_MISMATCH_EN.
- Defined, DMR mode: on mismatch the offending request is not issued (bus req=0, gnt=0 to G). debug_req_o[0:1] assert from the next cycle and stay high until SWITCH completes.
- Defined, TMR mode: the voted request still proceeds; debug_req_o is asserted only for the minority hart, until SWITCH.
- Not defined: debug_req_o is tied to 0; mismatches are only flagged and counted.

Test Plan:
- Independent pass-through: hart1 write addr=0x2000_0010, wdata=0xDEADBEEF → appears unchanged on bus lane 1 the same cycle; bus gnt/rvalid return to hart1 only; mismatch_o stays 0.
- Mode switch to TMR: mode_req_i=2 while hart0 has 1 outstanding → stays in DRAIN; after rvalid and sleep_i=3'b111 → mode_ready_o pulses once and mode_o=2.
- TMR single-hart divergence: harts 0/1/2 send addr 0x100/0x100/0x104 → bus lane 0 addr=0x100; mismatch_o pulses the next cycle; mismatch_hart_o=3'b100; cnt=1; rdata broadcast to all three harts.
- DMR divergence with the macro defined: wdata 0x1 vs 0x2 → no bus req; debug_req_o=2'b11 the next cycle, held until the switch back to mode 0.
- Counter saturation, CNT_W=2: 5 TMR mismatches → mismatch_cnt_o=3.
- Outstanding limit: bus withholds rvalid with 2 granted → third req sees gnt=0 and bus req=0 until rvalid.
